// File: rtl/wb_bus_arbiter_decoder.sv
// wb_bus_arbiter_decoder: single-master, N-slave Wishbone interconnect with address decode, bus error and timeout
module wb_bus_arbiter_decoder #(
  parameter int N_SLAVES = 8,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int DEC_W    = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m_cyc_i,
  input  logic                   m_stb_i,
  input  logic                   m_we_i,
  input  logic [AW-1:0]          m_addr_i,
  input  logic [DW-1:0]          m_data_i,
  input  logic [DW/8-1:0]        m_sel_i,
  output logic [DW-1:0]          m_data_o,
  output logic                   m_ack_o,
  output logic                   m_err_o,
  output logic [N_SLAVES-1:0]    s_cyc_o,
  output logic [N_SLAVES-1:0]    s_stb_o,
  output logic                   s_we_o,
  output logic [AW-1:0]          s_addr_o,
  output logic [DW-1:0]          s_data_o,
  output logic [DW/8-1:0]        s_sel_o,
  input  logic [N_SLAVES*DW-1:0] s_data_i,
  input  logic [N_SLAVES-1:0]    s_ack_i,
  output logic                   busy_o
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [DEC_W:0] NS = (DEC_W + 1)'(N_SLAVES);
  state_t state_q, state_d;
  logic [N_SLAVES-1:0] stb_q, stb_d;
  logic we_q, we_d, ack_q, ack_d, err_q, err_d, hit;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d, rdata_q, rdata_d, rdata_sel;
  logic [DW/8-1:0] sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DEC_W-1:0] dec;
  assign dec = m_addr_i[AW-1 -: DEC_W];
  // The one-hot strobe doubles as the slave selector for ack and read data
  assign hit = |(s_ack_i & stb_q);
  always_comb begin
    rdata_sel = '0;
    for (int k = 0; k < N_SLAVES; k++) rdata_sel = rdata_sel | (stb_q[k] ? s_data_i[k*DW +: DW] : '0);
  end
  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    if (state_q == IDLE) begin
      if (m_cyc_i && m_stb_i) begin
        we_d   = m_we_i;
        addr_d = m_addr_i;
        data_d = m_data_i;
        sel_d  = m_sel_i;
        cnt_d  = '0;
        if ({1'b0, dec} < NS) begin
          state_d = WAIT;
          stb_d   = N_SLAVES'(1) << dec;
        end else begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + 1'b1;
      if (!m_cyc_i) begin
        state_d = IDLE;
        stb_d   = '0;
      end else if (hit) begin
        state_d = RESP;
        stb_d   = '0;
        ack_d   = 1'b1;
        rdata_d = rdata_sel;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d = RESP;
        stb_d   = '0;
        err_d   = 1'b1;
        rdata_d = '0;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stb_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end
  assign m_data_o = rdata_q;
  assign m_ack_o  = ack_q;
  assign m_err_o  = err_q;
  assign s_cyc_o  = stb_q;
  assign s_stb_o  = stb_q;
  assign s_we_o   = we_q;
  assign s_addr_o = addr_q;
  assign s_data_o = data_q;
  assign s_sel_o  = sel_q;
  assign busy_o   = state_q != IDLE;
endmodule
